// File: rtl/mesh_router_sync.sv
// mesh_router_sync: clocked 5-port mesh router with XY routing, per-port input FIFOs and
// per-output arbiters. Define MESH_ROUTER_RR_ARB_EN for round-robin arbitration.
module mesh_router_sync #(
    parameter int         n       = 32,
    parameter int         XW      = 4,
    parameter int         YW      = 4,
    parameter int         srcx    = 0,
    parameter int         srcy    = 0,
    parameter int         DEPTH   = 4,
    parameter logic [4:0] PORT_EN = 5'b11111
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4:0]     in_req,
    output logic [4:0]     in_ack,
    input  logic [5*n-1:0] in_data,
    output logic [4:0]     out_req,
    input  logic [4:0]     out_ack,
    output logic [5*n-1:0] out_data,
    output logic           err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic         live_q, live_d;
    logic         err_q, err_d;
    logic [4:0]   head_vld;
    logic [4:0]   fifo_full;
    logic [n-1:0] head_data [5];
    logic [4:0]   route [5];
    logic [4:0]   drop;
    logic [4:0]   req [5];
    logic [4:0]   gnt [5];
    logic [4:0]   load;
    logic [4:0]   pop;
    logic [4:0]   ovld_q, ovld_d;
    logic [n-1:0] odata_q [5];
    logic [n-1:0] odata_d [5];

    // Dimension-ordered route: X first, then Y, else local (one-hot, bit = port)
    function automatic logic [4:0] route_of(
        input logic [XW-1:0] dx,
        input logic [YW-1:0] dy
    );
        logic [4:0] r;
        if (int'(dx) > srcx) r = 5'b00100;
        else if (int'(dx) < srcx) r = 5'b10000;
        else if (int'(dy) > srcy) r = 5'b00010;
        else if (int'(dy) < srcy) r = 5'b01000;
        else r = 5'b00001;
        return r;
    endfunction

    for (genvar i = 0; i < 5; i++) begin : g_port
        if (PORT_EN[i]) begin : g_fifo
            logic [n-1:0]  mem_q [DEPTH];
            logic [PW-1:0] wptr_q, wptr_d;
            logic [PW-1:0] rptr_q, rptr_d;
            logic          wr;

            // Advance write pointer on handshake, read pointer on pop
            always_comb begin
                wr     = in_req[i] & in_ack[i];
                wptr_d = wptr_q + PW'(wr);
                rptr_d = rptr_q + PW'(pop[i]);
            end

            // Pointer registers; clearing them flushes the FIFO
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                end
            end

            // Storage: validity is carried by the pointers alone
            always_ff @(posedge clk) begin
                if (wr) mem_q[wptr_q[AW-1:0]] <= in_data[i*n +: n];
            end

            assign fifo_full[i] = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
                                  && (wptr_q[AW] != rptr_q[AW]);
            assign head_vld[i]  = wptr_q != rptr_q;
            assign head_data[i] = mem_q[rptr_q[AW-1:0]];
            assign in_ack[i]    = live_q & ~fifo_full[i];
        end else begin : g_off
            assign fifo_full[i] = 1'b0;
            assign head_vld[i]  = 1'b0;
            assign head_data[i] = '0;
            assign in_ack[i]    = 1'b0;
        end
    end

    // Route heads, flag undeliverable flits, build per-output request vectors
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            route[i] = route_of(head_data[i][n-1 -: XW],
                                head_data[i][n-1-XW -: YW]);
            drop[i]  = head_vld[i]
                       & (((route[i] & PORT_EN) == 5'b0)
                          | ((i == 0) & route[i][0]));
        end
        for (int o = 0; o < 5; o++) begin
            load[o] = ~ovld_q[o] | out_ack[o];
            for (int i = 0; i < 5; i++)
                req[o][i] = head_vld[i] & ~drop[i] & route[i][o];
        end
    end

`ifdef MESH_ROUTER_RR_ARB_EN
    logic [2:0] ptr_q [5];
    logic [2:0] ptr_d [5];

    // Round-robin: search from the slot after the last winner
    always_comb begin
        int   idx;
        logic hit;
        idx = 0;
        hit = 1'b0;
        for (int o = 0; o < 5; o++) begin
            gnt[o]   = '0;
            ptr_d[o] = ptr_q[o];
            hit      = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                idx = (int'(ptr_q[o]) + k) % 5;
                if (load[o] && !hit && req[o][idx]) begin
                    gnt[o][idx] = 1'b1;
                    ptr_d[o]    = 3'(idx);
                    hit         = 1'b1;
                end
            end
        end
    end

    // Pointers restart at 4 so input 0 is searched first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < 5; o++) ptr_q[o] <= 3'd4;
        end else begin
            for (int o = 0; o < 5; o++) ptr_q[o] <= ptr_d[o];
        end
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        for (int o = 0; o < 5; o++)
            gnt[o] = load[o] ? (req[o] & (~req[o] + 5'd1)) : 5'b0;
    end
`endif

    // Pop granted or dropped heads, load output registers, latch error
    always_comb begin
        pop   = drop;
        err_d = err_q | (|drop);
        live_d = 1'b1;
        for (int o = 0; o < 5; o++) begin
            ovld_d[o]  = ovld_q[o] & ~out_ack[o];
            odata_d[o] = odata_q[o];
            for (int i = 0; i < 5; i++) begin
                if (gnt[o][i]) begin
                    pop[i]     = 1'b1;
                    ovld_d[o]  = 1'b1;
                    odata_d[o] = head_data[i];
                end
            end
        end
    end

    // Output stage, error flag and input-side liveness
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q <= 1'b0;
            err_q  <= 1'b0;
            ovld_q <= '0;
            for (int o = 0; o < 5; o++) odata_q[o] <= '0;
        end else begin
            live_q <= live_d;
            err_q  <= err_d;
            ovld_q <= ovld_d;
            for (int o = 0; o < 5; o++) odata_q[o] <= odata_d[o];
        end
    end

    // Disabled outputs are forced quiet
    always_comb begin
        out_req = ovld_q & PORT_EN;
        err     = err_q;
        for (int o = 0; o < 5; o++)
            out_data[o*n +: n] = PORT_EN[o] ? odata_q[o] : '0;
    end

endmodule
